// File: rtl/mem_stage_ctrl_if.sv
`timescale 1ns/1ps
// Data memory request/acknowledge bus.
// The MEM stage controller is the master. The data memory is the slave.
// The master holds dmem_req with a stable address, write enable and store data until dmem_ack.
// dmem_rdata is meaningful only in a cycle where dmem_ack is high.
interface mem_stage_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
`timescale 1ns/1ps
// MEM stage controller.
// It latches the load or store held in EX/MEM and drives it onto a variable-latency data memory bus.
// While the access is in flight it freezes the upstream stages and feeds NOPs into MEM/WB.
// An access is abandoned after TIMEOUT_CYCLES wait cycles, and misaligned or contradictory
// accesses are squashed with a one-cycle error pulse.
// State updates happen on the falling edge of clk, in step with the pipeline registers.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic             clk,
    input  logic             Reset_L,
    input  logic             MemRead_EX_MEM,
    input  logic             MemWrite_EX_MEM,
    input  logic [31:0]      Addr_EX_MEM,
    input  logic [31:0]      WrData_EX_MEM,
    mem_stage_ctrl_if.master dmem,
    output logic [31:0]      Data_memory_out,
    output logic             Stall_MEM,
    output logic             Bubble_MEM_WB,
    output logic             Mem_Error,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The last wait-counter value before the access is given up.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             abort;

    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             acc;
    logic             illegal;
    logic             start;
    logic             timeout_hit;

    // Classify the instruction sitting in EX/MEM.
    // Only an IDLE controller acts on it.
    always_comb begin
        acc         = MemRead_EX_MEM | MemWrite_EX_MEM;
        illegal     = (MemRead_EX_MEM & MemWrite_EX_MEM) |
                      (acc & (Addr_EX_MEM[1:0] != 2'b00));
        start       = (state == IDLE) & acc & ~illegal;
        timeout_hit = (wait_cnt == LAST_WAIT);
    end

    // Pipeline control is decoded from the state.
    // It is also decoded from the pending instruction, so the stall takes effect in the same cycle.
    always_comb begin
        Stall_MEM     = 1'b0;
        Bubble_MEM_WB = 1'b0;
        unique case (state)
            IDLE: begin
                Stall_MEM     = start;
                Bubble_MEM_WB = acc;
            end
            ACCESS: begin
                Stall_MEM     = 1'b1;
                Bubble_MEM_WB = 1'b1;
            end
            RESP: begin
                Stall_MEM     = 1'b0;
                Bubble_MEM_WB = abort;
            end
            default: begin
                Stall_MEM     = 1'b0;
                Bubble_MEM_WB = 1'b0;
            end
        endcase
    end

    // Sequencer: IDLE -> ACCESS -> RESP -> IDLE.
    // All bus outputs and the error pulse are registered here.
    always_ff @(negedge clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            wait_cnt <= '0;
            abort    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (start) begin
                        addr_q   <= {Addr_EX_MEM[31:2], 2'b00};
                        we_q     <= MemWrite_EX_MEM;
                        wdata_q  <= WrData_EX_MEM;
                        req_q    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ACCESS;
                    end else if (illegal) begin
                        err_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ack) begin
                        if (!we_q) begin
                            rdata_q <= dmem.dmem_rdata;
                        end
                        req_q <= 1'b0;
                        abort <= 1'b0;
                        state <= RESP;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        abort   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    abort <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    abort <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign Data_memory_out = rdata_q;
    assign Mem_Error       = err_q;
    assign Busy            = (state != IDLE);

endmodule
